mem_bus_arbiter: RTL and testbench

Sequencing arbiter between the CPU instruction-fetch port, the CPU data port, the base-RAM `sram_controller` and the `serial_controller`. It decodes each request's virtual address, grants one requester at a time, and holds the selected target's op strobes for a fixed number of cycles. It then returns read data with a one-cycle ack. The UART shares `base_ram_data[7:0]` with base RAM, so the block guarantees the SRAM and UART ops are never active together and inserts a bus turnaround after every UART access.

---
 rtl/mem_bus_arbiter_if.sv | 47 ++++
 rtl/mem_bus_arbiter.sv | 219 +++++++++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_bus_arbiter_if.sv
// Bus bundle between the CPU ports, base-RAM SRAM controller and UART for mem_bus_arbiter.
// The slave modport is the arbiter's view; master is the environment (CPU and targets).
interface mem_bus_arbiter_if;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_ack;

  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [3:0]  d_be;
  logic [31:0] d_rdata;
  logic        d_ack;

  logic        bus_err;

  logic        sram_read_op;
  logic        sram_write_op;
  logic [19:0] sram_addr;
  logic [31:0] sram_data_write;
  logic [3:0]  sram_byte_mask;
  logic [31:0] sram_data_read;

  logic        uart_read_op;
  logic        uart_write_op;
  logic [7:0]  uart_data_write;
  logic [7:0]  uart_data_read;
  logic [1:0]  uart_mode;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_be,
    input  sram_data_read, uart_data_read, uart_mode,
    output if_rdata, if_ack, d_rdata, d_ack, bus_err,
    output sram_read_op, sram_write_op, sram_addr, sram_data_write, sram_byte_mask,
    output uart_read_op, uart_write_op, uart_data_write
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_be,
    output sram_data_read, uart_data_read, uart_mode,
    input  if_rdata, if_ack, d_rdata, d_ack, bus_err,
    input  sram_read_op, sram_write_op, sram_addr, sram_data_write, sram_byte_mask,
    input  uart_read_op, uart_write_op, uart_data_write
  );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Fetch/data arbiter onto base-RAM SRAM and the UART sharing its low data byte; all outputs
// registered. Define MEM_ARB_ROUND_ROBIN_EN for round-robin tie-breaking instead of data priority.
module mem_bus_arbiter #(
  parameter int unsigned SRAM_CYCLES = 2,
  parameter int unsigned UART_CYCLES = 4
) (
  input logic              clk,
  input logic              rst,
  mem_bus_arbiter_if.slave bus
);

  localparam int unsigned MaxCycles = (SRAM_CYCLES > UART_CYCLES) ? SRAM_CYCLES : UART_CYCLES;
  localparam int unsigned CntW      = $clog2(MaxCycles + 1);
  localparam logic [31:0] UartData  = 32'hBFD0_03F8;
  localparam logic [31:0] UartStat  = 32'hBFD0_03FC;

  typedef enum logic [2:0] {StIdle, StSram, StUart, StQuick, StTurn} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            sel_data_q, sel_data_d;
  logic            quick_err_q, quick_err_d;

  logic [31:0] if_rdata_q, if_rdata_d, d_rdata_q, d_rdata_d;
  logic        if_ack_q, if_ack_d, d_ack_q, d_ack_d, bus_err_q, bus_err_d;
  logic        sram_rd_q, sram_rd_d, sram_wr_q, sram_wr_d;
  logic [19:0] sram_addr_q, sram_addr_d;
  logic [31:0] sram_wdata_q, sram_wdata_d;
  logic [3:0]  sram_be_q, sram_be_d;
  logic        uart_rd_q, uart_rd_d, uart_wr_q, uart_wr_d;
  logic [7:0]  uart_wdata_q, uart_wdata_d;

  logic        pick_data, grant, req_we, hit_sram, hit_udata, hit_ustat;
  logic [31:0] req_addr;
  logic        done;
  logic [31:0] rdata_new;

  // Priority is decided on raw requests; a port acked this cycle blocks rather than yields.
`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic last_data_q, last_data_d;
  assign pick_data = bus.d_req & (~bus.if_req | ~last_data_q);
`else
  assign pick_data = bus.d_req;
`endif
  assign grant     = pick_data ? (bus.d_req & ~d_ack_q) : (bus.if_req & ~if_ack_q);
  assign req_addr  = pick_data ? bus.d_addr : bus.if_addr;
  assign req_we    = pick_data & bus.d_we;
  assign hit_sram  = (req_addr[31:22] == 10'h200);
  assign hit_udata = pick_data & (req_addr == UartData);
  assign hit_ustat = pick_data & (req_addr == UartStat);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      sel_data_q   <= 1'b0;
      quick_err_q  <= 1'b0;
      if_rdata_q   <= '0;
      d_rdata_q    <= '0;
      if_ack_q     <= 1'b0;
      d_ack_q      <= 1'b0;
      bus_err_q    <= 1'b0;
      sram_rd_q    <= 1'b0;
      sram_wr_q    <= 1'b0;
      sram_addr_q  <= '0;
      sram_wdata_q <= '0;
      sram_be_q    <= '0;
      uart_rd_q    <= 1'b0;
      uart_wr_q    <= 1'b0;
      uart_wdata_q <= '0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      last_data_q  <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      sel_data_q   <= sel_data_d;
      quick_err_q  <= quick_err_d;
      if_rdata_q   <= if_rdata_d;
      d_rdata_q    <= d_rdata_d;
      if_ack_q     <= if_ack_d;
      d_ack_q      <= d_ack_d;
      bus_err_q    <= bus_err_d;
      sram_rd_q    <= sram_rd_d;
      sram_wr_q    <= sram_wr_d;
      sram_addr_q  <= sram_addr_d;
      sram_wdata_q <= sram_wdata_d;
      sram_be_q    <= sram_be_d;
      uart_rd_q    <= uart_rd_d;
      uart_wr_q    <= uart_wr_d;
      uart_wdata_q <= uart_wdata_d;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      last_data_q  <= last_data_d;
`endif
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    sel_data_d  = sel_data_q;
    quick_err_d = quick_err_q;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    last_data_d = last_data_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (grant) begin
          sel_data_d  = pick_data;
          quick_err_d = 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
          last_data_d = pick_data;
`endif
          if (hit_sram) begin
            state_d = StSram;
            cnt_d   = CntW'(SRAM_CYCLES - 1);
          end else if (hit_udata) begin
            // One extra count keeps the ack cycle inside StUart, ahead of the turnaround.
            state_d = StUart;
            cnt_d   = CntW'(UART_CYCLES);
          end else begin
            state_d     = StQuick;
            quick_err_d = ~hit_ustat;
          end
        end
      end
      StSram: begin
        if (cnt_q == '0) state_d = StIdle;
        else             cnt_d   = cnt_q - CntW'(1);
      end
      StUart: begin
        if (cnt_q == '0) state_d = StTurn;
        else             cnt_d   = cnt_q - CntW'(1);
      end
      StQuick: state_d = StIdle;
      StTurn:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    if_rdata_d   = if_rdata_q;
    d_rdata_d    = d_rdata_q;
    if_ack_d     = 1'b0;
    d_ack_d      = 1'b0;
    bus_err_d    = 1'b0;
    sram_rd_d    = sram_rd_q;
    sram_wr_d    = sram_wr_q;
    sram_addr_d  = sram_addr_q;
    sram_wdata_d = sram_wdata_q;
    sram_be_d    = sram_be_q;
    uart_rd_d    = uart_rd_q;
    uart_wr_d    = uart_wr_q;
    uart_wdata_d = uart_wdata_q;
    done         = 1'b0;
    rdata_new    = '0;
    unique case (state_q)
      StIdle: begin
        if (grant && hit_sram) begin
          sram_rd_d    = ~req_we;
          sram_wr_d    = req_we;
          sram_addr_d  = req_addr[21:2];
          sram_wdata_d = pick_data ? bus.d_wdata : '0;
          sram_be_d    = pick_data ? bus.d_be : 4'hF;
        end else if (grant && hit_udata) begin
          uart_rd_d    = ~req_we;
          uart_wr_d    = req_we;
          uart_wdata_d = bus.d_wdata[7:0];
        end
      end
      StSram: begin
        if (cnt_q == '0) begin
          sram_rd_d = 1'b0;
          sram_wr_d = 1'b0;
          done      = 1'b1;
          rdata_new = bus.sram_data_read;
        end
      end
      StUart: begin
        if (cnt_q == CntW'(1)) begin
          uart_rd_d = 1'b0;
          uart_wr_d = 1'b0;
          done      = 1'b1;
          rdata_new = {24'b0, bus.uart_data_read};
        end
      end
      StQuick: begin
        done      = 1'b1;
        bus_err_d = quick_err_q;
        rdata_new = quick_err_q ? 32'b0 : {30'b0, bus.uart_mode};
      end
      default: ;
    endcase
    if (done) begin
      if (sel_data_q) begin
        d_ack_d   = 1'b1;
        d_rdata_d = rdata_new;
      end else begin
        if_ack_d   = 1'b1;
        if_rdata_d = rdata_new;
      end
    end
  end

  assign bus.if_rdata        = if_rdata_q;
  assign bus.if_ack          = if_ack_q;
  assign bus.d_rdata         = d_rdata_q;
  assign bus.d_ack           = d_ack_q;
  assign bus.bus_err         = bus_err_q;
  assign bus.sram_read_op    = sram_rd_q;
  assign bus.sram_write_op   = sram_wr_q;
  assign bus.sram_addr       = sram_addr_q;
  assign bus.sram_data_write = sram_wdata_q;
  assign bus.sram_byte_mask  = sram_be_q;
  assign bus.uart_read_op    = uart_rd_q;
  assign bus.uart_write_op   = uart_wr_q;
  assign bus.uart_data_write = uart_wdata_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed, table-driven bench for mem_bus_arbiter (SRAM_CYCLES=2, UART_CYCLES=4).
module tb_mem_bus_arbiter;
  localparam int unsigned SramCycles = 2;
  localparam int unsigned UartCycles = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_bus_arbiter_if bus_if ();

  mem_bus_arbiter #(
    .SRAM_CYCLES(SramCycles),
    .UART_CYCLES(UartCycles)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus_if)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  // SRAM and UART ops must never overlap nor touch in adjacent cycles.
  int   excl_viol = 0;
  logic prev_sram = 1'b0;
  logic prev_uart = 1'b0;
  always @(negedge clk) begin
    if (((bus_if.sram_read_op | bus_if.sram_write_op) &&
         (bus_if.uart_read_op | bus_if.uart_write_op | prev_uart)) ||
        ((bus_if.uart_read_op | bus_if.uart_write_op) && prev_sram))
      excl_viol = excl_viol + 1;
    prev_sram = bus_if.sram_read_op | bus_if.sram_write_op;
    prev_uart = bus_if.uart_read_op | bus_if.uart_write_op;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        is_data;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] sram_rd;
    logic [7:0]  uart_rd;
    logic [1:0]  mode;
    int          lat;
    logic        chk_rdata;
    logic [31:0] rdata;
    logic        err;
    int          s_rd;
    int          s_wr;
    int          u_rd;
    int          u_wr;
    logic [19:0] s_addr;
  } vec_t;

  function automatic vec_t mk(input logic is_data, input logic we, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [3:0] be,
                              input logic [31:0] sram_rd, input logic [7:0] uart_rd,
                              input logic [1:0] mode, input int lat, input logic chk_rdata,
                              input logic [31:0] rdata, input logic err, input int s_rd,
                              input int s_wr, input int u_rd, input int u_wr,
                              input logic [19:0] s_addr);
    vec_t v;
    v.is_data = is_data; v.we = we; v.addr = addr; v.wdata = wdata; v.be = be;
    v.sram_rd = sram_rd; v.uart_rd = uart_rd; v.mode = mode; v.lat = lat;
    v.chk_rdata = chk_rdata; v.rdata = rdata; v.err = err; v.s_rd = s_rd; v.s_wr = s_wr;
    v.u_rd = u_rd; v.u_wr = u_wr; v.s_addr = s_addr;
    return v;
  endfunction

  vec_t vecs[12];

  task automatic idle_inputs();
    bus_if.if_req = 1'b0; bus_if.if_addr = '0;
    bus_if.d_req = 1'b0; bus_if.d_we = 1'b0; bus_if.d_addr = '0;
    bus_if.d_wdata = '0; bus_if.d_be = '0;
    bus_if.sram_data_read = '0; bus_if.uart_data_read = '0; bus_if.uart_mode = '0;
  endtask

  // Called at a negedge; the request is first seen at the next posedge (cycle t).
  task automatic run_vec(input int idx, input vec_t v);
    logic [31:0] other_before, rdata, w_cap;
    logic [19:0] a_cap;
    logic [3:0]  be_cap;
    logic [7:0]  uw_cap;
    logic        err;
    int s_rd, s_wr, u_rd, u_wr, lat, other_acks;
    s_rd = 0; s_wr = 0; u_rd = 0; u_wr = 0; lat = -1; other_acks = 0;
    rdata = '0; err = 1'b0; a_cap = '0; w_cap = '0; be_cap = '0; uw_cap = '0;
    other_before = v.is_data ? bus_if.if_rdata : bus_if.d_rdata;
    bus_if.sram_data_read = v.sram_rd;
    bus_if.uart_data_read = v.uart_rd;
    bus_if.uart_mode      = v.mode;
    if (v.is_data) begin
      bus_if.d_req = 1'b1; bus_if.d_we = v.we; bus_if.d_addr = v.addr;
      bus_if.d_wdata = v.wdata; bus_if.d_be = v.be;
    end else begin
      bus_if.if_req = 1'b1; bus_if.if_addr = v.addr;
    end
    for (int k = 1; k <= 20 && lat < 0; k++) begin
      @(negedge clk);
      if (bus_if.sram_read_op)  s_rd++;
      if (bus_if.sram_write_op) s_wr++;
      if (bus_if.uart_read_op)  u_rd++;
      if (bus_if.uart_write_op) u_wr++;
      if (bus_if.sram_read_op | bus_if.sram_write_op) begin
        a_cap = bus_if.sram_addr; w_cap = bus_if.sram_data_write; be_cap = bus_if.sram_byte_mask;
      end
      if (bus_if.uart_write_op) uw_cap = bus_if.uart_data_write;
      if (v.is_data ? bus_if.if_ack : bus_if.d_ack) other_acks++;
      if (v.is_data ? bus_if.d_ack : bus_if.if_ack) begin
        lat   = k;
        rdata = v.is_data ? bus_if.d_rdata : bus_if.if_rdata;
        err   = bus_if.bus_err;
      end
    end
    bus_if.if_req = 1'b0;
    bus_if.d_req  = 1'b0;
    check($sformatf("v%0d latency", idx), lat, v.lat);
    check($sformatf("v%0d bus_err", idx), {31'b0, err}, {31'b0, v.err});
    if (v.chk_rdata) check($sformatf("v%0d rdata", idx), rdata, v.rdata);
    check($sformatf("v%0d sram_rd_cycles", idx), s_rd, v.s_rd);
    check($sformatf("v%0d sram_wr_cycles", idx), s_wr, v.s_wr);
    check($sformatf("v%0d uart_rd_cycles", idx), u_rd, v.u_rd);
    check($sformatf("v%0d uart_wr_cycles", idx), u_wr, v.u_wr);
    check($sformatf("v%0d other_ack", idx), other_acks, 0);
    check($sformatf("v%0d other_rdata_hold", idx),
          v.is_data ? bus_if.if_rdata : bus_if.d_rdata, other_before);
    if (v.s_rd + v.s_wr > 0) check($sformatf("v%0d sram_addr", idx), {12'b0, a_cap}, {12'b0, v.s_addr});
    if (v.s_wr > 0) begin
      check($sformatf("v%0d sram_wdata", idx), w_cap, v.wdata);
      check($sformatf("v%0d sram_mask", idx), {28'b0, be_cap}, {28'b0, v.be});
    end
    if (v.u_wr > 0) check($sformatf("v%0d uart_wdata", idx), {24'b0, uw_cap}, {24'b0, v.wdata[7:0]});
    @(negedge clk);
    check($sformatf("v%0d post_ack_ops", idx),
          {28'b0, bus_if.sram_read_op, bus_if.sram_write_op, bus_if.uart_read_op,
           bus_if.uart_write_op}, 32'b0);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    int d_lat, f_lat, f_op, dc, fc, first, acks, wr_ops, lat;
    vecs[0]  = mk(0, 0, 32'h8000_0010, 32'h0, 4'h0, 32'h3C08_DEAD, 8'h00, 2'b00,
                  3, 1, 32'h3C08_DEAD, 0, 2, 0, 0, 0, 20'h00004);
    vecs[1]  = mk(1, 1, 32'hBFD0_03F8, 32'h0000_0041, 4'h1, 32'h0, 8'h00, 2'b00,
                  5, 0, 32'h0, 0, 0, 0, 0, 4, 20'h0);
    vecs[2]  = mk(1, 0, 32'hBFD0_03FC, 32'h0, 4'h0, 32'h0, 8'h00, 2'b10,
                  2, 1, 32'h0000_0002, 0, 0, 0, 0, 0, 20'h0);
    vecs[3]  = mk(0, 0, 32'h0000_1000, 32'h0, 4'h0, 32'hFFFF_FFFF, 8'hFF, 2'b11,
                  2, 1, 32'h0, 1, 0, 0, 0, 0, 20'h0);
    vecs[4]  = mk(1, 0, 32'h803F_FFFC, 32'h0, 4'hF, 32'h1234_5678, 8'h00, 2'b00,
                  3, 1, 32'h1234_5678, 0, 2, 0, 0, 0, 20'hFFFFF);
    vecs[5]  = mk(1, 1, 32'h8000_0004, 32'hCAFE_F00D, 4'b0011, 32'h0, 8'h00, 2'b00,
                  3, 0, 32'h0, 0, 0, 2, 0, 0, 20'h00001);
    vecs[6]  = mk(1, 0, 32'hBFD0_03F8, 32'h0, 4'h0, 32'h0, 8'hA5, 2'b00,
                  5, 1, 32'h0000_00A5, 0, 0, 0, 4, 0, 20'h0);
    vecs[7]  = mk(1, 0, 32'h8040_0000, 32'h0, 4'h0, 32'h5555_5555, 8'h00, 2'b00,
                  2, 1, 32'h0, 1, 0, 0, 0, 0, 20'h0);
    vecs[8]  = mk(0, 0, 32'hBFD0_03FC, 32'h0, 4'h0, 32'h0, 8'h00, 2'b11,
                  2, 1, 32'h0, 1, 0, 0, 0, 0, 20'h0);
    vecs[9]  = mk(1, 1, 32'hBFD0_03FC, 32'h0000_0055, 4'hF, 32'h0, 8'h00, 2'b01,
                  2, 0, 32'h0, 0, 0, 0, 0, 0, 20'h0);
    vecs[10] = mk(0, 0, 32'h803F_FFF0, 32'h0, 4'h0, 32'h0BAD_F00D, 8'h00, 2'b00,
                  3, 1, 32'h0BAD_F00D, 0, 2, 0, 0, 0, 20'hFFFFC);
    vecs[11] = mk(1, 0, 32'h7FFF_FFFC, 32'h0, 4'h0, 32'h0, 8'h00, 2'b00,
                  2, 1, 32'h0, 1, 0, 0, 0, 0, 20'h0);

    idle_inputs();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset if_rdata", bus_if.if_rdata, 32'h0);
    check("reset d_rdata", bus_if.d_rdata, 32'h0);
    check("reset sram_data_write", bus_if.sram_data_write, 32'h0);
    check("reset sram_addr", {12'b0, bus_if.sram_addr}, 32'h0);
    check("reset strobes", {bus_if.if_ack, bus_if.d_ack, bus_if.bus_err, bus_if.sram_read_op,
                            bus_if.sram_write_op, bus_if.uart_read_op, bus_if.uart_write_op,
                            bus_if.sram_byte_mask, bus_if.uart_data_write, 13'b0}, 32'h0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 12; i++) run_vec(i, vecs[i]);

    // UART write followed by a pending fetch: turnaround delays the next grant.
    bus_if.uart_mode = 2'b00; bus_if.sram_data_read = 32'h1111_2222;
    bus_if.d_req = 1'b1; bus_if.d_we = 1'b1; bus_if.d_addr = 32'hBFD0_03F8;
    bus_if.d_wdata = 32'h5A; bus_if.if_addr = 32'h8000_0020;
    d_lat = -1; f_lat = -1; f_op = -1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (k == 1) bus_if.if_req = 1'b1;
      if ((bus_if.sram_read_op | bus_if.sram_write_op) && f_op < 0) f_op = k;
      if (bus_if.d_ack && d_lat < 0) begin d_lat = k; bus_if.d_req = 1'b0; end
      if (bus_if.if_ack && f_lat < 0) begin f_lat = k; bus_if.if_req = 1'b0; end
    end
    check("turn d_ack latency", d_lat, 5);
    check("turn first sram op", f_op, 8);
    check("turn if_ack latency", f_lat, 10);
    check("turn if_rdata", bus_if.if_rdata, 32'h1111_2222);

    // Reset during the second cycle of an SRAM write; request stays asserted throughout.
    bus_if.d_req = 1'b1; bus_if.d_we = 1'b1; bus_if.d_addr = 32'h8000_0008;
    bus_if.d_wdata = 32'h0102_0304; bus_if.d_be = 4'hF;
    acks = 0; wr_ops = 0; lat = -1;
    for (int k = 1; k <= 15; k++) begin
      @(negedge clk);
      if (bus_if.d_ack) begin
        acks++;
        if (lat < 0) begin lat = k; bus_if.d_req = 1'b0; end
      end
      if (k >= 4 && bus_if.sram_write_op) wr_ops++;
      if (k == 2) begin
        check("rstmid op before reset", {31'b0, bus_if.sram_write_op}, 32'h1);
        rst = 1'b1;
      end
      if (k == 3) begin
        check("rstmid op after reset", {31'b0, bus_if.sram_write_op}, 32'h0);
        check("rstmid sram_addr after reset", {12'b0, bus_if.sram_addr}, 32'h0);
        rst = 1'b0;
      end
    end
    check("rstmid ack count", acks, 1);
    check("rstmid reissue latency", lat, 6);
    check("rstmid reissue op cycles", wr_ops, 2);

    // Simultaneous SRAM requests from both ports, starting from reset.
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    bus_if.sram_data_read = 32'h600D_CAFE;
    bus_if.d_we = 1'b0; bus_if.d_addr = 32'h8000_0100; bus_if.if_addr = 32'h8000_0000;
    bus_if.d_req = 1'b1; bus_if.if_req = 1'b1;
    dc = 0; fc = 0; first = 0;
    for (int k = 1; k <= 24; k++) begin
      @(negedge clk);
      if (bus_if.d_ack) begin dc++; if (first == 0) first = 1; end
      if (bus_if.if_ack) begin fc++; if (first == 0) first = 2; end
    end
    bus_if.d_req = 1'b0;
    check("tie first grant is data", first, 1);
`ifdef MEM_ARB_ROUND_ROBIN_EN
    bus_if.if_req = 1'b0;
    check("tie rr data acks", dc, 4);
    check("tie rr fetch acks", fc, 4);
`else
    check("tie fixed data acks", dc, 6);
    check("tie fixed fetch acks", fc, 0);
    lat = -1;
    for (int k = 25; k <= 40 && lat < 0; k++) begin
      @(negedge clk);
      if (bus_if.if_ack) lat = k;
    end
    bus_if.if_req = 1'b0;
    check("tie fixed fetch after release", lat, 27);
`endif
    repeat (4) @(negedge clk);

    check("mutual exclusion violations", excl_viol, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
